// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: canonical NOP, fetch FSM states, PC increment.
package rv32i_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register; one request in flight, 2 cycles/inst with 1-cycle memory.
// Stall freezes the output register; a response landing under stall parks in a one-entry skid.
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = rv32i_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  skid, skid_nxt;
    logic [31:0]  inst_nxt, inst_pc_nxt;
    logic         inst_valid_nxt;
    logic         discard, discard_nxt;
    logic         slot_free;

    assign slot_free = !inst_valid || !stall;
    assign imem_req  = (state == ISSUE) && !rst;
    assign imem_addr = pc;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        skid_nxt       = skid;
        discard_nxt    = discard;
        inst_nxt       = inst;
        inst_pc_nxt    = inst_pc;
        inst_valid_nxt = inst_valid;

        if (redirect_valid) begin
            pc_nxt         = redirect_pc & ~32'd3;
            inst_valid_nxt = 1'b0;
            inst_nxt       = NOP_INST;
            case (state)
                ISSUE: begin
                    // A grant in this cycle leaves the old fetch in flight; its data must be dropped.
                    if (imem_gnt) begin
                        discard_nxt = 1'b1;
                        state_nxt   = WAIT;
                    end
                end
                WAIT: begin
                    discard_nxt = !imem_rvalid;
                    if (imem_rvalid) begin
                        state_nxt = ISSUE;
                    end
                end
                default: state_nxt = ISSUE;
            endcase
        end else begin
            if (inst_valid && !stall) begin
                inst_valid_nxt = 1'b0;
                inst_nxt       = NOP_INST;
            end
            case (state)
                ISSUE: begin
                    if (imem_gnt) begin
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (discard) begin
                            discard_nxt = 1'b0;
                            state_nxt   = ISSUE;
                        end else if (slot_free) begin
                            inst_nxt       = imem_rdata;
                            inst_pc_nxt    = pc;
                            inst_valid_nxt = 1'b1;
                            pc_nxt         = pc + PC_STEP;
                            state_nxt      = ISSUE;
                        end else begin
                            skid_nxt  = imem_rdata;
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        inst_nxt       = skid;
                        inst_pc_nxt    = pc;
                        inst_valid_nxt = 1'b1;
                        pc_nxt         = pc + PC_STEP;
                        state_nxt      = ISSUE;
                    end
                end
                default: state_nxt = ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ISSUE;
            pc         <= RESET_PC;
            skid       <= '0;
            discard    <= 1'b0;
            inst       <= NOP_INST;
            inst_pc    <= RESET_PC;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            skid       <= skid_nxt;
            discard    <= discard_nxt;
            inst       <= inst_nxt;
            inst_pc    <= inst_pc_nxt;
            inst_valid <= inst_valid_nxt;
        end
    end

endmodule
